vh_expr_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational mixed-signedness expression cases.
- Evaluates one of eight opcode-selected expressions over two unsigned and two signed operands, using exact Verilog width and signedness context rules.
- Adds a valid/ready pipeline, a persistent signed accumulator and an error flag, so sequential synthesis and simulation can be cross-checked in the same flow.

---
 rtl/vh_expr_pipe.sv | 174 +++++++++++++++++
 tb/tb_vh_expr_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vh_expr_pipe.sv
// -----------------------------------------------------------------------------
// vh_expr_pipe
// Two-stage valid/ready pipeline that evaluates one of eight opcode-selected
// expressions over two unsigned and two signed operands. Every operand is
// explicitly extended to the result width, so each expression follows the
// width and signedness rules of a WY-bit Verilog context. A persistent signed
// accumulator supports multiply-accumulate and read-and-clear opcodes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   op         opcode
//   a_u, b_u   unsigned operands (b_u is also the shift amount)
//   a_s, b_s   signed operands
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   y          result, WY bits
//   err        result came from the reserved opcode
// -----------------------------------------------------------------------------
module vh_expr_pipe #(
  parameter int WU = 4,
  parameter int WS = 6,
  parameter int WY = WU + WS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [WU-1:0] a_u,
  input  logic [WU-1:0] b_u,
  input  logic [WS-1:0] a_s,
  input  logic [WS-1:0] b_s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WY-1:0] y,
  output logic          err
);

  typedef enum logic [2:0] {
    OP_MUL_US = 3'd0,
    OP_MUL_SS = 3'd1,
    OP_SUB_UU = 3'd2,
    OP_ASR    = 3'd3,
    OP_RED    = 3'd4,
    OP_MAC    = 3'd5,
    OP_CLR    = 3'd6,
    OP_RSV    = 3'd7
  } op_e;

  logic          s1_valid;
  logic          s2_valid;
  logic          s1_adv;
  logic          s2_adv;
  op_e           s1_op;
  logic [WU-1:0] s1_au;
  logic [WU-1:0] s1_bu;
  logic [WS-1:0] s1_as;
  logic [WS-1:0] s1_bs;
  logic [WY-1:0] acc;

  logic [WY-1:0]        zx_au;
  logic [WY-1:0]        zx_bu;
  logic [WY-1:0]        zx_as;
  logic [WY-1:0]        sx_as;
  logic [WY-1:0]        sx_bs;
  logic [WY-1:0]        prod_ss;
  logic signed [WY-1:0] asr;
  logic [31:0]          shamt;
  logic [WY-1:0]        res_y;
  logic [WY-1:0]        res_acc;
  logic                 res_err;

  // Elastic handshake: the output stage moves when it is empty or being
  // drained, and the input stage moves when it is empty or can hand its beat
  // on. in_ready is therefore a combinational function of out_ready.
  always_comb begin
    s2_adv    = !s2_valid || out_ready;
    s1_adv    = !s1_valid || s2_adv;
    in_ready  = s1_adv;
    out_valid = s2_valid;
  end

  // Operand extensions to the full result width. Unsigned-context opcodes use
  // the zero-extended forms, signed-context opcodes the sign-extended forms;
  // a WY x WY product truncated to WY bits is correct modulo 2^WY for both.
  always_comb begin
    zx_au   = {{(WY-WU){1'b0}}, s1_au};
    zx_bu   = {{(WY-WU){1'b0}}, s1_bu};
    zx_as   = {{(WY-WS){1'b0}}, s1_as};
    sx_as   = {{(WY-WS){s1_as[WS-1]}}, s1_as};
    sx_bs   = {{(WY-WS){s1_bs[WS-1]}}, s1_bs};
    prod_ss = sx_as * sx_bs;
    shamt   = 32'(s1_bu);
    asr     = $signed(sx_as) >>> s1_bu;
  end

  // Result and next-accumulator evaluation for the beat sitting in stage 1.
  // The accumulator value computed here is only committed when the beat
  // actually moves into stage 2, which keeps updates in acceptance order and
  // prevents a stalled beat from applying its update twice.
  always_comb begin
    res_y   = '0;
    res_err = 1'b0;
    res_acc = acc;
    case (s1_op)
      OP_MUL_US: res_y = zx_as * zx_bu;
      OP_MUL_SS: res_y = prod_ss;
      OP_SUB_UU: res_y = zx_au - zx_as;
      OP_ASR: begin
        if (shamt >= WY) begin
          res_y = {WY{s1_as[WS-1]}};
        end else begin
          res_y = asr;
        end
      end
      OP_RED: res_y = {{(WY-4){1'b0}}, &s1_au, ~|s1_bu, ^s1_as, !s1_bs};
      OP_MAC: begin
        res_acc = acc + prod_ss;
        res_y   = res_acc;
      end
      OP_CLR: begin
        res_y   = acc;
        res_acc = '0;
      end
      OP_RSV: res_err = 1'b1;
      default: res_y = '0;
    endcase
  end

  // Stage 1 captures the operands and opcode of an accepted beat. Operands
  // are sampled only on acceptance, so the source may change them freely
  // while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_MUL_US;
      s1_au    <= '0;
      s1_bu    <= '0;
      s1_as    <= '0;
      s1_bs    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op_e'(op);
        s1_au <= a_u;
        s1_bu <= b_u;
        s1_as <= a_s;
        s1_bs <= b_s;
      end
    end
  end

  // Stage 2 registers the result and owns the accumulator. While the output
  // is valid but not accepted, nothing here changes, so y/err/out_valid hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      y        <= '0;
      err      <= 1'b0;
      acc      <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y   <= res_y;
        err <= res_err;
        acc <= res_acc;
      end
    end
  end

endmodule

// File: tb/tb_vh_expr_pipe.sv
// -----------------------------------------------------------------------------
// tb_vh_expr_pipe
// Scoreboard bench for vh_expr_pipe. An acceptance watcher pushes the
// reference-model result of every accepted beat into a queue; a monitor pops
// and compares whenever the DUT hands over a result. Directed beats follow
// the documented scenarios, then a randomized phase with backpressure runs.
// -----------------------------------------------------------------------------
module tb_vh_expr_pipe;

  localparam int WU   = 4;
  localparam int WS   = 6;
  localparam int WY   = WU + WS;
  localparam int MASK = (1 << WY) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'd0;
  logic [WU-1:0] a_u = '0;
  logic [WU-1:0] b_u = '0;
  logic [WS-1:0] a_s = '0;
  logic [WS-1:0] b_s = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WY-1:0] y;
  logic          err;

  typedef struct {
    int  y;
    bit  err;
    time t;
    bit  lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   modelAcc = 0;
  bit   latChk = 1'b0;
  bit   stimDone = 1'b0;

  always #5 clk = ~clk;

  vh_expr_pipe #(.WU(WU), .WS(WS), .WY(WY)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_u       (a_u),
    .b_u       (b_u),
    .a_s       (a_s),
    .b_s       (b_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
  );

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model: evaluates each opcode with plain integer arithmetic on
  // the operand values and reduces the answer modulo 2^WY at the end.
  function automatic exp_t modelBeat(input logic [2:0] opv,
                                     input logic [WU-1:0] av,
                                     input logic [WU-1:0] bv,
                                     input logic [WS-1:0] asv,
                                     input logic [WS-1:0] bsv);
    exp_t m;
    int au  = int'(av);
    int bu  = int'(bv);
    int asz = int'(asv);
    int as  = int'($signed(asv));
    int bs  = int'($signed(bsv));
    int r   = 0;
    m.err = 1'b0;
    case (opv)
      3'd0: r = asz * bu;
      3'd1: r = as * bs;
      3'd2: r = au - asz;
      3'd3: r = (bu >= WY) ? ((as < 0) ? -1 : 0) : (as >>> bu);
      3'd4: r = ((au == (1 << WU) - 1) ? 8 : 0) + ((bu == 0) ? 4 : 0)
              + (($countones(asv) % 2) * 2) + ((bs == 0) ? 1 : 0);
      3'd5: begin
        modelAcc = (modelAcc + as * bs) & MASK;
        r = modelAcc;
      end
      3'd6: begin
        r = modelAcc;
        modelAcc = 0;
      end
      default: m.err = 1'b1;
    endcase
    m.y   = r & MASK;
    m.t   = 0;
    m.lat = 1'b0;
    return m;
  endfunction

  // Acceptance watcher: a beat is taken at the next rising edge when
  // in_valid && in_ready hold at the preceding falling edge. Reset discards
  // everything in flight and clears the model accumulator.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        modelAcc = 0;
      end else if (in_valid && in_ready) begin
        m = modelBeat(op, a_u, b_u, a_s, b_s);
        m.t = $time;
        m.lat = latChk;
        sb.push_back(m);
      end
    end
  end

  // Monitor: a result is consumed at the next rising edge when out_valid &&
  // out_ready hold at the falling edge. A stalled result must stay put.
  initial begin
    exp_t e;
    logic [WY-1:0] hy;
    logic he;
    bit hp;
    hy = '0;
    he = 1'b0;
    hp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hp = 1'b0;
      end else begin
        if (hp) begin
          checkOutput("hold_valid", int'(out_valid), 1);
          checkOutput("hold_y", int'(y), int'(hy));
          checkOutput("hold_err", int'(err), int'(he));
        end
        hp = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: actual y=0x%0h required=no result", y);
          end else begin
            e = sb.pop_front();
            checkOutput("y", int'(y), e.y);
            checkOutput("err", int'(err), int'(e.err));
            if (e.lat) checkOutput("latency", int'($time - e.t), 20);
          end
        end else if (out_valid) begin
          hy = y;
          he = err;
          hp = 1'b1;
        end
      end
    end
  end

  // Presents one beat and holds it until accepted; returns 1 ns after the
  // accepting edge with in_valid dropped.
  task automatic applyStimulus(input int o, input int au, input int bu,
                               input int as, input int bs);
    bit got = 1'b0;
    int n = 0;
    op       = 3'(o);
    a_u      = WU'(au);
    b_u      = WU'(bu);
    a_s      = WS'(as);
    b_s      = WS'(bs);
    in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: actual in_ready=0 required=1 within 200 cycles");
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: actual pending=%0d required=0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual time=%0t required=finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_y", int'(y), 0);
    checkOutput("reset_err", int'(err), 0);
    @(posedge clk);
    #1;

    $display("[TB] directed: unsigned-context multiply, signed multiply, shifts");
    latChk = 1'b1;
    applyStimulus(0, 0, 2, 63, 0);
    waitIdle();
    applyStimulus(1, 0, 0, -3, 5);
    applyStimulus(3, 0, 3, -32, 0);
    applyStimulus(3, 0, 15, -32, 0);
    waitIdle();

    $display("[TB] directed: accumulate chain and clear");
    applyStimulus(5, 0, 0, 2, 3);
    applyStimulus(5, 0, 0, -1, 4);
    applyStimulus(5, 0, 0, 7, 7);
    applyStimulus(6, 0, 0, 0, 0);
    applyStimulus(5, 0, 0, 1, 1);
    waitIdle();

    $display("[TB] directed: stream with output stall");
    latChk = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          applyStimulus(2, int'($urandom_range(15)), 0, int'($urandom_range(63)), 0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("stall_in_ready", int'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    applyStimulus(2, 0, 0, 1, 0);
    waitIdle();

    $display("[TB] directed: reserved opcode, reductions, accumulator kept");
    latChk = 1'b1;
    applyStimulus(7, 5, 5, 5, 5);
    applyStimulus(4, 15, 0, 1, 0);
    applyStimulus(6, 0, 0, 0, 0);
    waitIdle();

    $display("[TB] directed: asynchronous reset with beats in flight");
    applyStimulus(5, 0, 0, 3, 3);
    applyStimulus(5, 0, 0, 2, 2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_acc", int'(dut.acc), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(6, 0, 0, 0, 0);
    waitIdle();

    $display("[TB] random: 150 beats with backpressure");
    latChk = 1'b0;
    stimDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(int'($urandom_range(7)), int'($urandom_range(15)),
                        int'($urandom_range(15)), int'($urandom_range(63)),
                        int'($urandom_range(63)));
        end
        stimDone = 1'b1;
      end
      begin
        while (!stimDone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
